// File: rtl/pkt_stream_pkg.sv
// pkt_stream_pkg: shared FSM encoding, payload mode codes and default ctrl markers
package pkt_stream_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0, S_LOAD = 3'd1, S_SEND = 3'd2, S_GAP = 3'd3, S_DONE = 3'd4;
  localparam logic [1:0] MODE_INC = 2'd0, MODE_LFSR = 2'd1, MODE_CONST = 2'd2, MODE_RSVD = 2'd3;
  localparam logic [7:0] HDR_CTRL_DEF = 8'hFF, EOP_CTRL_DEF = 8'h01;
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with synchronous reload and step enable
module lfsr_galois #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] SEED = '1,
  parameter logic [WIDTH-1:0] TAPS = '0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= SEED;
    else if (load) q <= SEED;
    else if (step) q <= (q >> 1) ^ (q[0] ? TAPS : '0);
endmodule

// File: rtl/pkt_stream_gen.sv
// pkt_stream_gen: programmable packet source for the data/ctrl/wr/rdy write interface
module pkt_stream_gen import pkt_stream_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int LEN_W = 16,
  parameter int CNT_W = 16,
  parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = CTRL_WIDTH'(HDR_CTRL_DEF),
  parameter logic [CTRL_WIDTH-1:0] EOP_CTRL = CTRL_WIDTH'(EOP_CTRL_DEF),
  parameter logic [63:0] LFSR_SEED = 64'hACE1_0000_0000_0001,
  parameter logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [LEN_W-1:0]      pkt_words,
  input  logic [CNT_W-1:0]      num_pkts,
  input  logic [7:0]            gap_cycles,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [LEN_W-1:0]      word_count
);
  state_t state;
  logic [1:0] mode_r;
  logic [LEN_W-1:0] words_r, wc_nxt;
  logic [CNT_W-1:0] num_r, cnt_nxt;
  logic [7:0] gap_r, gap_cnt;
  logic [31:0] pay_cnt;
  logic [DATA_WIDTH-1:0] lfsr_q, body;
  logic idle, last, fin, inc_mode;

  assign idle = state == S_IDLE || state == S_DONE;
  assign out_wr = state == S_SEND && out_rdy;
  assign busy = !idle;
  assign done = state == S_DONE;
  assign last = word_count == words_r - LEN_W'(1);
  assign wc_nxt = word_count + LEN_W'(1);
  assign cnt_nxt = &pkt_count ? pkt_count : pkt_count + CNT_W'(1);
  assign fin = (num_r != '0 && cnt_nxt == num_r) || stop;
  assign inc_mode = mode_r == MODE_INC || mode_r == MODE_RSVD;
  assign body = mode_r == MODE_LFSR ? lfsr_q : mode_r == MODE_CONST ? '1 : DATA_WIDTH'(pay_cnt);

  // the LFSR output is consumed at staging, so it steps as each body word is staged
  lfsr_galois #(
    .WIDTH(DATA_WIDTH),
    .SEED (DATA_WIDTH'(LFSR_SEED)),
    .TAPS (DATA_WIDTH'(LFSR_TAPS))
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(idle && start),
    .step(out_wr && !last && mode_r == MODE_LFSR),
    .q   (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      out_data <= '0;
      out_ctrl <= '0;
      pkt_count <= '0;
      word_count <= '0;
      pay_cnt <= '0;
      mode_r <= '0;
      words_r <= LEN_W'(2);
      num_r <= '0;
      gap_r <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          mode_r <= mode;
          words_r <= pkt_words < LEN_W'(2) ? LEN_W'(2) : pkt_words;
          num_r <= num_pkts;
          gap_r <= gap_cycles;
          pkt_count <= '0;
          pay_cnt <= '0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          out_data <= DATA_WIDTH'({16'(pkt_count), 16'(words_r)});
          out_ctrl <= HDR_CTRL;
          word_count <= '0;
          state <= S_SEND;
        end
        S_SEND: if (out_rdy) begin
          if (last) begin
            pkt_count <= cnt_nxt;
            gap_cnt <= gap_r;
            state <= fin ? S_DONE : gap_r != '0 ? S_GAP : S_LOAD;
          end else begin
            out_data <= body;
            out_ctrl <= wc_nxt == words_r - LEN_W'(1) ? EOP_CTRL : '0;
            word_count <= wc_nxt;
            if (inc_mode) pay_cnt <= pay_cnt + 32'd1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          state <= stop ? S_DONE : gap_cnt == 8'd1 ? S_LOAD : S_GAP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_stream_gen.sv
// tb_pkt_stream_gen: directed checks of packet format, gaps, back-pressure, modes, stop and reset
module tb_pkt_stream_gen;
  logic clk = 0, rst = 0, start = 0, stop = 0, out_rdy = 1;
  logic [1:0] mode = 0;
  logic [15:0] pkt_words = 0, num_pkts = 0;
  logic [7:0] gap_cycles = 0;
  logic [63:0] out_data;
  logic [7:0] out_ctrl;
  logic out_wr, busy, done;
  logic [15:0] pkt_count, word_count;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [63:0] cap_d[$];
  logic [7:0] cap_c[$];
  int cap_t[$];
  logic [63:0] exp_d[8] = '{64'h4, 64'h0, 64'h1, 64'h2, 64'h1_0004, 64'h3, 64'h4, 64'h5};
  logic [7:0] exp_c[8] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01};

  pkt_stream_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .pkt_words(pkt_words), .num_pkts(num_pkts), .gap_cycles(gap_cycles),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .busy(busy), .done(done), .pkt_count(pkt_count), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (out_wr) begin
    cap_d.push_back(out_data);
    cap_c.push_back(out_ctrl);
    cap_t.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] cd(input int i);
    return i < cap_d.size() ? cap_d[i] : 64'hx;
  endfunction

  function automatic logic [7:0] cc(input int i);
    return i < cap_c.size() ? cap_c[i] : 8'hx;
  endfunction

  task automatic run(input logic [1:0] m, input logic [15:0] w, input logic [15:0] n, input logic [7:0] g);
    @(negedge clk);
    mode = m; pkt_words = w; num_pkts = n; gap_cycles = g;
    cap_d.delete(); cap_c.delete(); cap_t.delete();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    check(tag, done, 1);
  endtask

  task automatic wait_at(input logic [15:0] pc, input logic [15:0] wc, input string tag);
    for (int i = 0; i < 2000 && !(out_wr && pkt_count == pc && word_count == wc); i++) @(negedge clk);
    check(tag, out_wr && pkt_count == pc && word_count == wc, 1);
  endtask

  initial begin
    #1;
    check("rst_wr", out_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_pktcnt", pkt_count, 0);
    check("rst_wc", word_count, 0);
    @(negedge clk);
    rst = 1;

    run(0, 4, 2, 2);
    wait_done("inc_done");
    check("inc_len", cap_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("inc_d%0d", i), cd(i), exp_d[i]);
      check($sformatf("inc_c%0d", i), cc(i), exp_c[i]);
    end
    check("inc_gap", cap_t.size() == 8 ? cap_t[4] - cap_t[3] : -1, 4);
    check("inc_tight", cap_t.size() == 8 ? cap_t[3] - cap_t[0] : -1, 3);
    check("inc_pktcnt", pkt_count, 2);
    check("inc_busy", busy, 0);
    check("inc_wr", out_wr, 0);

    run(0, 4, 2, 2);
    wait_at(0, 2, "bp_reach");
    out_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_wr", out_wr, 0);
      check("bp_data", out_data, 1);
      check("bp_wc", word_count, 2);
    end
    out_rdy = 1;
    wait_done("bp_done");
    check("bp_len", cap_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_d%0d", i), cd(i), exp_d[i]);
      check($sformatf("bp_c%0d", i), cc(i), exp_c[i]);
    end
    check("bp_pktcnt", pkt_count, 2);

    run(1, 3, 1, 0);
    wait_done("lfsr_done");
    check("lfsr_len", cap_d.size(), 3);
    check("lfsr_hdr", cd(0), 64'h3);
    check("lfsr_b1", cd(1), 64'hACE1_0000_0000_0001);
    check("lfsr_b2", cd(2), 64'h8E70_8000_0000_0000);
    check("lfsr_c2", cc(2), 8'h01);
    check("lfsr_pktcnt", pkt_count, 1);

    run(0, 1, 1, 0);
    wait_done("clamp_done");
    check("clamp_len", cap_d.size(), 2);
    check("clamp_hdr", cd(0), 64'h2);
    check("clamp_c0", cc(0), 8'hFF);
    check("clamp_c1", cc(1), 8'h01);
    check("clamp_pktcnt", pkt_count, 1);

    run(0, 4, 0, 0);
    wait_at(5, 2, "stop_reach");
    stop = 1;
    wait_done("stop_done");
    stop = 0;
    check("stop_pktcnt", pkt_count, 6);
    check("stop_len", cap_d.size(), 24);
    check("stop_hdr5", cd(20), 64'h5_0004);
    check("stop_last_d", cd(23), 64'd17);
    check("stop_last_c", cc(23), 8'h01);

    run(0, 8, 0, 0);
    wait_at(1, 3, "ar_reach");
    #2 rst = 0;
    #1;
    check("ar_wr", out_wr, 0);
    check("ar_busy", busy, 0);
    check("ar_data", out_data, 0);
    check("ar_ctrl", out_ctrl, 0);
    check("ar_pktcnt", pkt_count, 0);
    check("ar_wc", word_count, 0);
    @(negedge clk);
    rst = 1;
    run(0, 4, 1, 0);
    wait_done("ar_done");
    check("ar_hdr", cd(0), 64'h4);
    check("ar_hdr_c", cc(0), 8'hFF);
    check("ar_pkt_after", pkt_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
